ext_arbiter: RTL and testbench

EXT_ARBITER -- requirements
Module: ext_arbiter

---
 rtl/ext_arbiter.sv | 121 ++++++++++++
 tb/tb_ext_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_arbiter.sv
// Two-requester round-robin front end for a shared combinational sign extender.
// One transaction in flight: operand is registered on accept, result captured one cycle later.
module ext_arbiter #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [IN_W-1:0]  req_imm0,
    input  logic [IN_W-1:0]  req_imm1,
    input  logic [1:0]       req_signop,
    output logic [1:0]       req_ready,
    output logic [IN_W-1:0]  ext_in,
    output logic             ext_signop,
    input  logic [OUT_W-1:0] ext_out,
    output logic [1:0]       resp_valid,
    output logic [OUT_W-1:0] resp_data,
    input  logic [1:0]       resp_ready,
    output logic             busy,
    output logic [7:0]       served_cnt
);

    // state | meaning
    // IDLE  | waiting for a request; grant offered combinationally
    // DRIVE | operand registered, sign extender result settling
    // RESP  | result held for the owner until it accepts
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [IN_W-1:0]   ext_in_q, ext_in_d;
    logic              ext_signop_q, ext_signop_d;
    logic [OUT_W-1:0]  resp_data_q, resp_data_d;
    logic [7:0]        served_cnt_q, served_cnt_d;
    logic              grant;
    logic [1:0]        ready_c;
    logic [1:0]        resp_valid_c;

    // With both requesting the one not served last wins; otherwise the lone requester.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~req_valid[0];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ext_in_d     = ext_in_q;
        ext_signop_d = ext_signop_q;
        resp_data_d  = resp_data_q;
        served_cnt_d = served_cnt_q;
        ready_c      = 2'b00;
        resp_valid_c = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ready_c[grant] = 1'b1;
                    ext_in_d       = grant ? req_imm1 : req_imm0;
                    ext_signop_d   = req_signop[grant];
                    owner_d        = grant;
                    state_d        = DRIVE;
                end
            end
            DRIVE: begin
                resp_data_d = ext_out;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid_c[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    served_cnt_d = served_cnt_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ext_in_q     <= '0;
            ext_signop_q <= 1'b0;
            resp_data_q  <= '0;
            served_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ext_in_q     <= ext_in_d;
            ext_signop_q <= ext_signop_d;
            resp_data_q  <= resp_data_d;
            served_cnt_q <= served_cnt_d;
        end
    end

    // The grant is combinational from inputs, so it is masked while reset is held.
    assign req_ready  = ready_c & {2{rst_n}};
    assign resp_valid = resp_valid_c;
    assign busy       = (state_q != IDLE);
    assign ext_in     = ext_in_q;
    assign ext_signop = ext_signop_q;
    assign resp_data  = resp_data_q;
    assign served_cnt = served_cnt_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed and randomized checks of ext_arbiter against a transaction-level model,
// with a behavioural sign extender closing the ext_in -> ext_out loop.
module tb_ext_arbiter;

    localparam int IN_W  = 24;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [IN_W-1:0]  req_imm0, req_imm1;
    logic [1:0]       req_signop;
    logic [1:0]       req_ready;
    logic [IN_W-1:0]  ext_in;
    logic             ext_signop;
    logic [OUT_W-1:0] ext_out;
    logic [1:0]       resp_valid;
    logic [OUT_W-1:0] resp_data;
    logic [1:0]       resp_ready;
    logic             busy;
    logic [7:0]       served_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_cnt;

    always #5 clk = ~clk;

    ext_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_imm0(req_imm0),
        .req_imm1(req_imm1), .req_signop(req_signop), .req_ready(req_ready),
        .ext_in(ext_in), .ext_signop(ext_signop), .ext_out(ext_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .busy(busy), .served_cnt(served_cnt)
    );

    assign ext_out = ext_signop ? {{(OUT_W-IN_W){ext_in[IN_W-1]}}, ext_in}
                                : {{(OUT_W-IN_W){1'b0}}, ext_in};

    function automatic logic [31:0] ext_model(input logic [23:0] v, input logic s);
        if (s && v >= 24'h800000) return 32'hFF000000 + 32'(v);
        return 32'(v);
    endfunction

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        step();
        step();
        rst_n = 1'b1;
        model_cnt = 8'd0;
    endtask

    // Inputs for the IDLE cycle are already driven by the caller.
    task automatic txn_check(input logic w, input logic [23:0] imm, input logic sop,
                             input int bp, input logic [1:0] v_after);
        logic [31:0] exp_data;
        logic r;
        exp_data = ext_model(imm, sop);
        #1;
        chk("grant", 32'(req_ready), 32'(onehot(w)));
        chk("idle_busy", 32'(busy), 32'd0);
        step();
        req_valid = v_after;
        #1;
        chk("drive_busy", 32'(busy), 32'd1);
        chk("drive_resp_valid", 32'(resp_valid), 32'd0);
        chk("drive_ext_in", 32'(ext_in), 32'(imm));
        chk("drive_ext_signop", 32'(ext_signop), 32'(sop));
        chk("drive_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("resp_valid", 32'(resp_valid), 32'(onehot(w)));
        chk("resp_data", resp_data, exp_data);
        for (int i = 0; i < bp; i++) begin
            r = 1'($urandom_range(0, 1));
            resp_ready = w ? {1'b0, r} : {r, 1'b0};
            step();
            chk("bp_resp_valid", 32'(resp_valid), 32'(onehot(w)));
            chk("bp_resp_data", resp_data, exp_data);
            chk("bp_ext_in", 32'(ext_in), 32'(imm));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = onehot(w) | 2'($urandom_range(0, 3));
        step();
        resp_ready = 2'b00;
        model_cnt = model_cnt + 8'd1;
        chk("served_cnt", 32'(served_cnt), 32'(model_cnt));
        chk("done_resp_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  pending;
        logic [23:0] p_imm [2];
        logic [1:0]  p_sop;
        logic        last, win;
        int          acc_n;
        int          acc_cyc [8];
        logic        acc_who [8];

        req_imm0 = '0;
        req_imm1 = '0;
        req_signop = 2'b00;
        resp_ready = 2'b00;
        req_valid = 2'b11;
        rst_n = 1'b0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_served", 32'(served_cnt), 32'd0);
        chk("rst_ext_in", 32'(ext_in), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        do_reset();

        // sign-extend from requester 0, then zero-extend from requester 1
        req_valid = 2'b01; req_imm0 = 24'hFF2609; req_signop = 2'b01;
        txn_check(1'b0, 24'hFF2609, 1'b1, 0, 2'b00);
        chk("sx_value", resp_data, 32'hFFFF2609);
        chk("sx_served", 32'(served_cnt), 32'd1);
        req_valid = 2'b10; req_imm1 = 24'hFF2609; req_signop = 2'b00;
        txn_check(1'b1, 24'hFF2609, 1'b0, 0, 2'b00);
        chk("zx_value", resp_data, 32'h00FF2609);

        // round-robin with both always valid and results always accepted
        do_reset();
        req_valid = 2'b11; req_imm0 = 24'h012345; req_imm1 = 24'h012345;
        req_signop = 2'b01; resp_ready = 2'b11;
        acc_n = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req_ready != 2'b00 && acc_n < 8) begin
                acc_cyc[acc_n] = c;
                acc_who[acc_n] = req_ready[1];
                acc_n++;
            end
            if (resp_valid != 2'b00) chk("rr_data", resp_data, 32'h00012345);
            step();
        end
        chk("rr_accepts", 32'(acc_n >= 4), 32'd1);
        if (acc_n >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_order", 32'(acc_who[k]), 32'(k % 2));
                chk("rr_cycle", 32'(acc_cyc[k]), 32'(3 * k));
            end
        end

        // backpressure on requester 0 while requester 1 waits
        do_reset();
        req_valid = 2'b01; req_imm0 = 24'h8ABCDE; req_signop = 2'b01;
        txn_check(1'b0, 24'h8ABCDE, 1'b1, 5, 2'b10);
        req_imm1 = 24'h00BEEF; req_signop = 2'b00;
        txn_check(1'b1, 24'h00BEEF, 1'b0, 0, 2'b00);

        // reset while in DRIVE
        req_valid = 2'b01; req_imm0 = 24'h123456;
        step();
        chk("drv_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("drv_rst_busy", 32'(busy), 32'd0);
        chk("drv_rst_req_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("drv_rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("drv_rst_served", 32'(served_cnt), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b01);
        step();
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);

        // randomized traffic, 256 transactions to wrap the counter
        do_reset();
        pending = 2'b00;
        p_sop = 2'b00;
        last = 1'b1;
        for (int t = 0; t < 256; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    p_imm[i] = 24'($urandom);
                    p_sop[i] = 1'($urandom_range(0, 1));
                end
            end
            if (pending == 2'b00) begin
                int i = $urandom_range(0, 1);
                pending[i] = 1'b1;
                p_imm[i] = 24'($urandom);
                p_sop[i] = 1'($urandom_range(0, 1));
            end
            if (pending == 2'b11) win = ~last;
            else win = pending[1];
            req_valid = pending;
            req_imm0 = p_imm[0];
            req_imm1 = p_imm[1];
            req_signop = p_sop;
            pending[win] = 1'b0;
            last = win;
            txn_check(win, p_imm[win], p_sop[win], $urandom_range(0, 2), pending);
        end
        chk("wrap", 32'(served_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
